// File: rtl/hr_pkg.sv
// Shared definitions for the heart-rate measurement path.
// Contents:
//   hr_state_e  - controller FSM states
//   *_DEF       - default parameter values for hr_meas_ctrl
//   REFRACT_TICKS_DEF - default refractory length in clk cycles
//   cnt_w()     - width of a counter holding 0..n-1
//   sat_mul8()  - 8x8 multiply, 16-bit product, saturated to 8 bits
package hr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    MEASURE,
    REPORT,
    LOST
  } hr_state_e;

  localparam int unsigned TICKS_PER_MS_DEF  = 50000;
  localparam int unsigned WINDOW_MS_DEF     = 15000;
  localparam int unsigned BPM_SCALE_DEF     = 4;
  localparam int unsigned REFRACT_MS_DEF    = 250;
  localparam int unsigned TIMEOUT_MS_DEF    = 3000;
  localparam int unsigned REFRACT_TICKS_DEF = REFRACT_MS_DEF * TICKS_PER_MS_DEF;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [7:0] sat_mul8(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    return (p > 16'd255) ? 8'hFF : p[7:0];
  endfunction

endpackage

// File: rtl/hr_beat_sync.sv
// Pulse conditioner for a raw asynchronous sensor input.
// 2-FF synchroniser, rising-edge detect and refractory filter. An accepted
// edge appears on beat_acc_o three clk cycles after the raw rise.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   clear_i      - arms the filter so the next edge is accepted; edges are
//                  ignored while it is high
//   pulse_i      - raw asynchronous pulse, active-high
//   beat_acc_o   - one-cycle accepted-edge pulse
module hr_beat_sync
  import hr_pkg::*;
#(
  parameter int unsigned REFRACT_TICKS = REFRACT_TICKS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic pulse_i,
  output logic beat_acc_o
);

  localparam int unsigned RW = cnt_w(REFRACT_TICKS + 1);
  localparam logic [RW-1:0] R_MAX = RW'(REFRACT_TICKS);

  logic          s1_q, s2_q, s3_q;
  logic          acc_q, acc_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          edge_w, ok_w;

  assign edge_w = s2_q & ~s3_q;
  // rcnt_q = cycles since last accepted edge, saturating at R_MAX
  assign ok_w   = (rcnt_q >= R_MAX);

  always_comb begin
    acc_d  = edge_w & ok_w & ~clear_i;
    rcnt_d = rcnt_q;
    if (clear_i) begin
      rcnt_d = R_MAX;
    end else if (acc_d) begin
      rcnt_d = RW'(1);
    end else if (rcnt_q < R_MAX) begin
      rcnt_d = rcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      s3_q   <= 1'b0;
      acc_q  <= 1'b0;
      rcnt_q <= '0;
    end else begin
      s1_q   <= pulse_i;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      acc_q  <= acc_d;
      rcnt_q <= rcnt_d;
    end
  end

  assign beat_acc_o = acc_q;

endmodule

// File: rtl/hr_meas_ctrl.sv
// Heart-rate measurement controller: schedules fixed-length windows, counts
// accepted beats per window, reports BPM with a one-cycle strobe and flags
// sensor loss when beats stop.
// Ports:
//   clk, reset   - clock, asynchronous active-high reset
//   enable       - 1 runs measurements, 0 aborts to IDLE
//   beat_in      - raw asynchronous heartbeat pulse
//   bpm          - last reported rate, saturating at 255
//   bpm_valid    - one-cycle strobe, bpm updated in the same cycle
//   busy         - high in ARM, MEASURE and REPORT
//   sensor_lost  - sticky; set on timeout, cleared on ARM entry or report
// Build option: define HR_AVG_EN to report the rounded mean of the current
// and previous window results.
module hr_meas_ctrl
  import hr_pkg::*;
#(
  parameter int unsigned TICKS_PER_MS = TICKS_PER_MS_DEF,
  parameter int unsigned WINDOW_MS    = WINDOW_MS_DEF,
  parameter int unsigned BPM_SCALE    = BPM_SCALE_DEF,
  parameter int unsigned REFRACT_MS   = REFRACT_MS_DEF,
  parameter int unsigned TIMEOUT_MS   = TIMEOUT_MS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       beat_in,
  output logic [7:0] bpm,
  output logic       bpm_valid,
  output logic       busy,
  output logic       sensor_lost
);

  localparam int unsigned PRE_W = cnt_w(TICKS_PER_MS);
  localparam int unsigned WIN_W = cnt_w(WINDOW_MS);
  localparam int unsigned TO_W  = cnt_w(TIMEOUT_MS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_MS - 1);
  // The window-start cycle is prescaler count 0, so counting resumes at 1.
  localparam logic [PRE_W-1:0] PRE_START = (TICKS_PER_MS > 1) ? PRE_W'(1) : '0;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_MS - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_MS - 1);
  localparam logic [7:0]       SCALE8   = 8'(BPM_SCALE);

  hr_state_e        state_q, state_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       bpm_q, bpm_d;
  logic             valid_q, valid_d;
  logic             lost_q, lost_d;
  logic             beat_acc, ms_tick;
  logic [7:0]       raw_bpm;
`ifdef HR_AVG_EN
  logic [7:0]       prev_q, prev_d;
  logic             first_q, first_d;
  logic [8:0]       avg_sum;
`endif

  hr_beat_sync #(
    .REFRACT_TICKS(REFRACT_MS * TICKS_PER_MS)
  ) u_sync (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (state_q == IDLE),
    .pulse_i   (beat_in),
    .beat_acc_o(beat_acc)
  );

  assign ms_tick = (pre_q == PRE_LAST);
  assign raw_bpm = sat_mul8(cnt_q, SCALE8);
`ifdef HR_AVG_EN
  assign avg_sum = {1'b0, prev_q} + {1'b0, raw_bpm} + 9'd1;
`endif

  always_comb begin
    state_d = state_q;
    pre_d   = ms_tick ? '0 : pre_q + 1'b1;
    win_d   = win_q;
    to_d    = to_q;
    cnt_d   = cnt_q;
    bpm_d   = bpm_q;
    valid_d = 1'b0;
    lost_d  = lost_q;
`ifdef HR_AVG_EN
    prev_d  = prev_q;
    first_d = first_q;
`endif

    case (state_q)
      IDLE: begin
        pre_d = '0;
        win_d = '0;
        to_d  = '0;
        cnt_d = '0;
        if (enable) begin
          state_d = ARM;
          lost_d  = 1'b0;
        end
      end
      ARM, LOST: begin
        if (state_q == LOST) pre_d = '0;
        if (beat_acc) begin
          state_d = MEASURE;
          cnt_d   = 8'd1;
          pre_d   = PRE_START;
          win_d   = '0;
          to_d    = '0;
`ifdef HR_AVG_EN
          first_d = 1'b1;
`endif
        end else if (state_q == ARM && ms_tick) begin
          if (to_q == TO_LAST) begin
            state_d = LOST;
            lost_d  = 1'b1;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end
      MEASURE: begin
        if (beat_acc) begin
          to_d = '0;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end
        if (ms_tick) begin
          win_d = win_q + 1'b1;
          if (!beat_acc) to_d = to_q + 1'b1;
          if (!beat_acc && to_q == TO_LAST) begin
            state_d = LOST;
            lost_d  = 1'b1;
          end else if (win_q == WIN_LAST) begin
            state_d = REPORT;
          end
        end
      end
      REPORT: begin
        valid_d = 1'b1;
        lost_d  = 1'b0;
`ifdef HR_AVG_EN
        bpm_d   = first_q ? raw_bpm : avg_sum[8:1];
        prev_d  = raw_bpm;
        first_d = 1'b0;
`else
        bpm_d   = raw_bpm;
`endif
        // Report cycle doubles as the start cycle of the next window.
        state_d = MEASURE;
        pre_d   = PRE_START;
        win_d   = '0;
        cnt_d   = beat_acc ? 8'd1 : 8'd0;
        if (beat_acc) to_d = '0;
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d = IDLE;
      valid_d = 1'b0;
      bpm_d   = bpm_q;
      lost_d  = lost_q;
`ifdef HR_AVG_EN
      prev_d  = prev_q;
      first_d = first_q;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      win_q   <= '0;
      to_q    <= '0;
      cnt_q   <= '0;
      bpm_q   <= '0;
      valid_q <= 1'b0;
      lost_q  <= 1'b0;
`ifdef HR_AVG_EN
      prev_q  <= '0;
      first_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      win_q   <= win_d;
      to_q    <= to_d;
      cnt_q   <= cnt_d;
      bpm_q   <= bpm_d;
      valid_q <= valid_d;
      lost_q  <= lost_d;
`ifdef HR_AVG_EN
      prev_q  <= prev_d;
      first_q <= first_d;
`endif
    end
  end

  assign bpm         = bpm_q;
  assign bpm_valid   = valid_q;
  assign busy        = (state_q == ARM) || (state_q == MEASURE) || (state_q == REPORT);
  assign sensor_lost = lost_q;

endmodule

// File: tb/tb_hr_meas_ctrl.sv
// Directed bench for hr_meas_ctrl: 1 ms = 10 clk, 100 ms windows,
// 5 ms refractory, 50 ms timeout. A second instance uses BPM_SCALE=20.
module tb_hr_meas_ctrl;

  logic       clk = 1'b0;
  logic       reset, enable, en4, beat_in;
  logic [7:0] bpm, bpm4;
  logic       bpm_valid, busy, sensor_lost, v4, busy4, lost4;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  logic [7:0]  vq[$];
  logic [7:0]  q4[$];
  int unsigned busy_low = 0;
  logic        trk = 1'b0;

  always #5 clk = ~clk;

  hr_meas_ctrl #(
    .TICKS_PER_MS(10), .WINDOW_MS(100), .BPM_SCALE(4), .REFRACT_MS(5), .TIMEOUT_MS(50)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .beat_in(beat_in),
    .bpm(bpm), .bpm_valid(bpm_valid), .busy(busy), .sensor_lost(sensor_lost)
  );

  hr_meas_ctrl #(
    .TICKS_PER_MS(10), .WINDOW_MS(100), .BPM_SCALE(20), .REFRACT_MS(5), .TIMEOUT_MS(50)
  ) dut4 (
    .clk(clk), .reset(reset), .enable(en4), .beat_in(beat_in),
    .bpm(bpm4), .bpm_valid(v4), .busy(busy4), .sensor_lost(lost4)
  );

  always @(negedge clk) begin
    if (bpm_valid) vq.push_back(bpm);
    if (v4) q4.push_back(bpm4);
    if (trk && !busy) busy_low++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raw beats every 'period' cycles, 3-cycle pulses, optional bounce.
  task automatic drive_beats(input int unsigned period, input int unsigned bounce,
                             input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      beat_in = 1'b1;
      cyc(3);
      beat_in = 1'b0;
      if (bounce > 0) begin
        cyc(bounce - 3);
        beat_in = 1'b1;
        cyc(3);
        beat_in = 1'b0;
        cyc(period - bounce - 3);
      end else begin
        cyc(period - 3);
      end
    end
  endtask

  task automatic go_idle;
    enable = 1'b0;
    cyc(5);
    vq.delete();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; en4 = 1'b0; beat_in = 1'b0;
    cyc(3);
    @(negedge clk);
    chk("rst_bpm", bpm, 0);
    chk("rst_valid", bpm_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lost", sensor_lost, 0);
    reset = 1'b0;
    cyc(2);

    // steady 20 ms beats: 5 per window -> 20 bpm
    enable = 1'b1;
    cyc(1);
    trk = 1'b1;
    cyc(1);
    drive_beats(200, 0, 16);
    trk = 1'b0;
    chk("t1_busy_low", busy_low, 0);
    chk("t1_nvalid", vq.size(), 3);
    foreach (vq[i]) chk("t1_bpm", vq[i], 20);
    go_idle();

    // bounce 2 ms after each beat is rejected
    enable = 1'b1;
    cyc(2);
    drive_beats(200, 20, 11);
    chk("t2a_nvalid", vq.size(), 2);
    foreach (vq[i]) chk("t2a_bpm", vq[i], 20);
    go_idle();

    // bounce exactly 5 ms later is accepted
    enable = 1'b1;
    cyc(2);
    drive_beats(200, 50, 11);
    chk("t2b_nvalid", vq.size(), 2);
    foreach (vq[i]) chk("t2b_bpm", vq[i], 40);
    go_idle();

    // three beats then silence: lost 500 cycles after last accepted edge
    enable = 1'b1;
    cyc(2);
    drive_beats(200, 0, 3);
    cyc(302);
    @(negedge clk);
    chk("t3_lost_early", sensor_lost, 0);
    chk("t3_busy_early", busy, 1);
    cyc(1);
    @(negedge clk);
    chk("t3_lost", sensor_lost, 1);
    chk("t3_busy", busy, 0);
    chk("t3_bpm", bpm, 40);
    chk("t3_nvalid", vq.size(), 0);

    // disable keeps sensor_lost; re-enable arms and clears it
    enable = 1'b0;
    cyc(1);
    @(negedge clk);
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_lost", sensor_lost, 1);
    enable = 1'b1;
    cyc(1);
    @(negedge clk);
    chk("t5_arm_busy", busy, 1);
    chk("t5_arm_lost", sensor_lost, 0);
    cyc(1);
    drive_beats(200, 0, 2);
    cyc(100);
    enable = 1'b0;
    cyc(1);
    @(negedge clk);
    chk("t5_abort_busy", busy, 0);
    cyc(700);
    chk("t5_nvalid", vq.size(), 0);
    chk("t5_bpm", bpm, 40);
    go_idle();

    // asynchronous reset mid-window, then a clean first report
    enable = 1'b1;
    cyc(2);
    drive_beats(200, 0, 2);
    reset = 1'b1;
    #1;
    chk("t6_bpm", bpm, 0);
    chk("t6_busy", busy, 0);
    chk("t6_lost", sensor_lost, 0);
    chk("t6_valid", bpm_valid, 0);
    cyc(2);
    reset = 1'b0;
    cyc(2);
    drive_beats(200, 0, 6);
    chk("t6_nvalid", vq.size(), 1);
    foreach (vq[i]) chk("t6_bpm_rep", vq[i], 20);
    go_idle();

    // window of 5 beats then window of 10 beats
    enable = 1'b1;
    cyc(2);
    drive_beats(200, 0, 5);
    drive_beats(200, 50, 5);
    cyc(10);
    chk("t7_nvalid", vq.size(), 2);
    if (vq.size() == 2) begin
      chk("t7_first", vq[0], 20);
`ifdef HR_AVG_EN
      chk("t7_second", vq[1], 30);
`else
      chk("t7_second", vq[1], 40);
`endif
    end
    go_idle();

    // BPM_SCALE=20, beats every 5 ms: 20 beats -> 400 saturates to 255
    en4 = 1'b1;
    cyc(2);
    drive_beats(50, 0, 21);
    cyc(5);
    @(negedge clk);
    chk("t4_busy", busy4, 1);
    chk("t4_lost", lost4, 0);
    en4 = 1'b0;
    cyc(2);
    chk("t4_nvalid", q4.size(), 1);
    foreach (q4[i]) chk("t4_bpm", q4[i], 255);
    chk("t4_main_idle", vq.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
